astar_backtrace: RTL

//  Downstream path-recovery stage of the A* maze solver. While the solver FSM holds backtrace_en, the block walks the

---
 rtl/astar_pkg.sv | 40 ++++
 rtl/astar_backtrace.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/astar_pkg.sv
// Shared A* maze constants, coordinate type and backtrace state encoding.
// Used by astar_backtrace and the solver FSM.
package astar_pkg;

   localparam int GRID_ROWS = 10;
   localparam int GRID_COLS = 10;
   localparam int MAX_STEPS = GRID_ROWS * GRID_COLS;
   localparam int MAP_W     = GRID_ROWS * GRID_COLS;

   localparam logic [3:0] START_ROW = 4'd9;
   localparam logic [3:0] START_COL = 4'd0;
   localparam logic [3:0] END_ROW   = 4'd0;
   localparam logic [3:0] END_COL   = 4'd9;

   localparam logic [3:0] ROW_LIM   = 4'(GRID_ROWS);
   localparam logic [3:0] COL_LIM   = 4'(GRID_COLS);
   localparam logic [6:0] STEP_LAST = 7'(MAX_STEPS - 1);

   typedef struct packed {
      logic [3:0] row;
      logic [3:0] col;
   } coord_t;

   localparam coord_t START_C = '{row: START_ROW, col: START_COL};
   localparam coord_t END_C   = '{row: END_ROW,   col: END_COL};

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      EMIT = 3'd1,
      READ = 3'd2,
      WAIT = 3'd3,
      DONE = 3'd4,
      HOLD = 3'd5
   } bt_state_t;

   function automatic logic [6:0] cell_addr(input coord_t c);
      return ({3'b000, c.row} * 7'd10) + {3'b000, c.col};
   endfunction

endpackage

// File: rtl/astar_backtrace.sv
// Walks the parent-pointer RAM from goal back to start, streaming each path cell over valid/ready.
// Optional visited-cell bitmap path_map is built only when BACKTRACE_MARK_EN is defined.
module astar_backtrace
   import astar_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             backtrace_en,
   output logic             parent_rd_en,
   output logic [6:0]       parent_rd_addr,
   input  logic [7:0]       parent_rd_data,
   output logic             path_valid,
   input  logic             path_ready,
   output logic [3:0]       path_row,
   output logic [3:0]       path_col,
   output logic [6:0]       path_len,
   output logic             backtrace_done,
   output logic             bt_error,
   output logic [MAP_W-1:0] path_map
);

   bt_state_t   state_q;
   coord_t      cur_q;
   logic [6:0]  step_q;
   logic [6:0]  len_q;
   logic        valid_q;
   logic [3:0]  row_q;
   logic [3:0]  col_q;
   logic        rd_en_q;
   logic [6:0]  rd_addr_q;
   logic        done_q;
   logic        err_q;

   coord_t      parent_s;
   logic        parent_bad_s;
   logic        abort_s;
   logic        start_s;
   logic        hs_s;

   assign parent_s     = coord_t'(parent_rd_data);
   assign parent_bad_s = (parent_s.row >= ROW_LIM) || (parent_s.col >= COL_LIM) || (parent_s == cur_q);
   assign abort_s      = !backtrace_en && ((state_q == EMIT) || (state_q == READ) || (state_q == WAIT));
   assign start_s      = (state_q == IDLE) && backtrace_en;
   assign hs_s         = (state_q == EMIT) && backtrace_en && valid_q && path_ready;

   // Backtrace FSM; abort on a dropped enable takes priority over any in-flight step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cur_q     <= END_C;
         step_q    <= 7'd0;
         len_q     <= 7'd0;
         valid_q   <= 1'b0;
         row_q     <= 4'd0;
         col_q     <= 4'd0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= 7'd0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         rd_en_q <= 1'b0;
         if (abort_s) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            len_q     <= 7'd0;
            row_q     <= 4'd0;
            col_q     <= 4'd0;
            rd_addr_q <= 7'd0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (backtrace_en) begin
                     state_q <= EMIT;
                     cur_q   <= END_C;
                     row_q   <= END_ROW;
                     col_q   <= END_COL;
                     valid_q <= 1'b1;
                     len_q   <= 7'd0;
                     step_q  <= 7'd0;
                     err_q   <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                  end
               end
               EMIT: begin
                  if (hs_s) begin
                     len_q   <= len_q + 7'd1;
                     valid_q <= 1'b0;
                     if (cur_q == START_C) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end else if (step_q == STEP_LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                     end else begin
                        state_q   <= READ;
                        step_q    <= step_q + 7'd1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= cell_addr(cur_q);
                     end
                  end else begin
                     state_q <= EMIT;
                  end
               end
               READ: begin
                  state_q <= WAIT;
               end
               WAIT: begin
                  cur_q <= parent_s;
                  if (parent_bad_s) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end else begin
                     state_q <= EMIT;
                     valid_q <= 1'b1;
                     row_q   <= parent_s.row;
                     col_q   <= parent_s.col;
                  end
               end
               DONE: begin
                  state_q <= HOLD;
               end
               HOLD: begin
                  if (!backtrace_en) begin
                     state_q <= IDLE;
                  end else begin
                     state_q <= HOLD;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign parent_rd_en   = rd_en_q;
   assign parent_rd_addr = rd_addr_q;
   assign path_valid     = valid_q;
   assign path_row       = row_q;
   assign path_col       = col_q;
   assign path_len       = len_q;
   assign backtrace_done = done_q;
   assign bt_error       = err_q;

`ifdef BACKTRACE_MARK_EN
   logic [MAP_W-1:0] map_q;

   // Visited-cell bitmap; cur_q is the cell on offer while in EMIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         map_q <= '0;
      end else if (start_s) begin
         map_q <= '0;
      end else if (hs_s) begin
         map_q[cell_addr(cur_q)] <= 1'b1;
      end else begin
         map_q <= map_q;
      end
   end

   assign path_map = map_q;
`else
   logic unused_start_s;
   assign unused_start_s = start_s;
   assign path_map       = '0;
`endif

endmodule
